// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single memory port.
// Round-robin ties, optional locked bursts, one-cycle read return.
module mem_port_arbiter #(
  parameter int ADDR_W    = 11,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              lock0,
  input  logic              lock1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] mem_q
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  localparam logic [3:0] BURST    = 4'(MAX_BURST);
  localparam logic       CAN_LOCK = (MAX_BURST > 1);

  state_e              state_q, state_d;
  logic [3:0]          beat_cnt_q, beat_cnt_d;
  logic                last_winner_q, last_winner_d;
  logic                rvalid0_q, rvalid0_d;
  logic                rvalid1_q, rvalid1_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_data_q, mem_data_d;
  logic [3:0]          beat_inc;

  // Grant selection: owner-only in OWNn, round-robin on ties in IDLE
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          if (req0 && req1) begin
            gnt0 = last_winner_q;
            gnt1 = !last_winner_q;
          end else begin
            gnt0 = req0;
            gnt1 = req1;
          end
        end
        OWN0: gnt0 = req0;
        OWN1: gnt1 = req1;
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_wren = (gnt0 && we0) || (gnt1 && we1);
    mem_addr = mem_addr_q;
    mem_data = mem_data_q;
    if (gnt0) begin
      mem_addr = addr0;
      mem_data = wdata0;
    end else if (gnt1) begin
      mem_addr = addr1;
      mem_data = wdata1;
    end
  end

  assign beat_inc = beat_cnt_q + 4'd1;

  always_comb begin
    state_d       = state_q;
    beat_cnt_d    = beat_cnt_q;
    last_winner_d = last_winner_q;
    if (gnt0) last_winner_d = 1'b0;
    if (gnt1) last_winner_d = 1'b1;
    unique case (state_q)
      IDLE: begin
        beat_cnt_d = 4'd0;
        if (gnt0 && lock0 && CAN_LOCK) begin
          state_d    = OWN0;
          beat_cnt_d = 4'd1;
        end else if (gnt1 && lock1 && CAN_LOCK) begin
          state_d    = OWN1;
          beat_cnt_d = 4'd1;
        end
      end
      OWN0: begin
        if (gnt0) begin
          if (!lock0 || beat_inc >= BURST) begin
            state_d    = IDLE;
            beat_cnt_d = 4'd0;
          end else begin
            beat_cnt_d = beat_inc;
          end
        end else if (!lock0) begin
          state_d    = IDLE;
          beat_cnt_d = 4'd0;
        end
      end
      OWN1: begin
        if (gnt1) begin
          if (!lock1 || beat_inc >= BURST) begin
            state_d    = IDLE;
            beat_cnt_d = 4'd0;
          end else begin
            beat_cnt_d = beat_inc;
          end
        end else if (!lock1) begin
          state_d    = IDLE;
          beat_cnt_d = 4'd0;
        end
      end
      default: begin
        state_d    = IDLE;
        beat_cnt_d = 4'd0;
      end
    endcase
  end

  always_comb begin
    rvalid0_d  = gnt0 && !we0;
    rvalid1_d  = gnt1 && !we1;
    mem_addr_d = mem_addr;
    mem_data_d = mem_data;
    if (rst) begin
      mem_addr_d = '0;
      mem_data_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      beat_cnt_q    <= 4'd0;
      last_winner_q <= 1'b1;
      rvalid0_q     <= 1'b0;
      rvalid1_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      beat_cnt_q    <= beat_cnt_d;
      last_winner_q <= last_winner_d;
      rvalid0_q     <= rvalid0_d;
      rvalid1_q     <= rvalid1_d;
    end
    mem_addr_q <= mem_addr_d;
    mem_data_q <= mem_data_d;
  end

  // Masking with rst drops a read whose return lands in the reset cycle
  assign rvalid0 = rvalid0_q && !rst;
  assign rvalid1 = rvalid1_q && !rst;
  assign rdata0  = mem_q;
  assign rdata1  = mem_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a one-cycle-latency
// memory model on port B.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic        lock0 = 0, lock1 = 0;
  logic [10:0] addr0 = '0, addr1 = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;
  logic        gnt0, gnt1, rvalid0, rvalid1, mem_wren;
  logic [31:0] rdata0, rdata1, mem_data, mem_q;
  logic [10:0] mem_addr;

  logic [31:0] mem [0:2047];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 32'hC0DE_0000 + i;
  end

  always @(posedge clk) begin
    if (mem_wren) mem[mem_addr] <= mem_data;
    mem_q <= mem[mem_addr];
  end

  mem_port_arbiter #(.ADDR_W(11), .DATA_W(32), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .lock0(lock0), .lock1(lock1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_wren(mem_wren), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_q(mem_q)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset with a pending write request
    rst = 1; req0 = 1; we0 = 1; addr0 = 11'h5; wdata0 = 32'h1234;
    tick(); tick();
    #2;
    chk("rst_gnt0", gnt0, 0);
    chk("rst_wren", mem_wren, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_data", mem_data, 0);
    chk("rst_rv0", rvalid0, 0);
    chk("rst_rv1", rvalid1, 0);

    // tie from reset: requester 0 first
    rst = 0; req0 = 1; req1 = 1; we0 = 0; we1 = 0;
    addr0 = 11'h010; addr1 = 11'h020;
    #2;
    chk("tie_gnt0", gnt0, 1);
    chk("tie_gnt1_lo", gnt1, 0);
    chk("tie_addr0", mem_addr, 11'h010);
    chk("tie_wren", mem_wren, 0);
    tick();
    req0 = 0;
    #2;
    chk("tie_gnt1", gnt1, 1);
    chk("tie_gnt0_lo", gnt0, 0);
    chk("tie_rv0", rvalid0, 1);
    chk("tie_rd0", rdata0, 32'hC0DE_0010);
    chk("tie_addr1", mem_addr, 11'h020);
    tick();
    req1 = 0;
    #2;
    chk("tie_rv1", rvalid1, 1);
    chk("tie_rv0_lo", rvalid0, 0);
    chk("tie_rd1", rdata1, 32'hC0DE_0020);
    chk("hold_addr", mem_addr, 11'h020);
    chk("idle_gnt", {gnt0, gnt1}, 0);
    tick();
    #2;
    chk("tie_rv1_lo", rvalid1, 0);

    // write then read on requester 1
    req1 = 1; we1 = 1; addr1 = 11'h055; wdata1 = 32'hDEAD_BEEF;
    #2;
    chk("wr_gnt1", gnt1, 1);
    chk("wr_wren", mem_wren, 1);
    chk("wr_addr", mem_addr, 11'h055);
    chk("wr_data", mem_data, 32'hDEAD_BEEF);
    tick();
    we1 = 0;
    #2;
    chk("rd_gnt1", gnt1, 1);
    chk("rd_wren", mem_wren, 0);
    chk("wr_no_rv", rvalid1, 0);
    tick();
    req1 = 0;
    #2;
    chk("rd_rv1", rvalid1, 1);
    chk("rd_data", rdata1, 32'hDEAD_BEEF);
    tick();

    // burst cap: 4 x gnt0, gnt1, gnt0
    req0 = 1; lock0 = 1; addr0 = 11'h001;
    req1 = 1; lock1 = 0; addr1 = 11'h002;
    for (int i = 0; i < 6; i++) begin
      #2;
      chk($sformatf("cap_gnt0_%0d", i), gnt0, (i != 4));
      chk($sformatf("cap_gnt1_%0d", i), gnt1, (i == 4));
      chk($sformatf("cap_rv0_%0d", i), rvalid0, (i >= 1 && i != 5));
      chk($sformatf("cap_rv1_%0d", i), rvalid1, (i == 5));
      tick();
    end
    // owner idles and unlocks: no grant this cycle
    req0 = 0; lock0 = 0;
    #2;
    chk("unl_gnt1_lo", gnt1, 0);
    chk("unl_gnt0_lo", gnt0, 0);
    chk("unl_rv0", rvalid0, 1);
    tick();
    #2;
    chk("unl_gnt1", gnt1, 1);
    tick();
    req1 = 0;
    tick();

    // early unlock on the third grant
    req0 = 1; lock0 = 1; req1 = 1;
    #2;
    chk("eu_gnt0_a", {gnt0, gnt1}, 2'b10);
    tick();
    #2;
    chk("eu_gnt0_b", {gnt0, gnt1}, 2'b10);
    tick();
    lock0 = 0;
    #2;
    chk("eu_gnt0_c", {gnt0, gnt1}, 2'b10);
    tick();
    req0 = 0;
    #2;
    chk("eu_gnt1", {gnt0, gnt1}, 2'b01);
    tick();
    req1 = 0;
    tick();

    // idle owner blocks the other requester
    req1 = 1; lock1 = 1;
    #2;
    chk("own1_gnt1", gnt1, 1);
    tick();
    req1 = 0; req0 = 1;
    #2;
    chk("own1_blk_a", gnt0, 0);
    tick();
    #2;
    chk("own1_blk_b", gnt0, 0);
    tick();
    lock1 = 0;
    #2;
    chk("own1_rel", {gnt0, gnt1}, 2'b00);
    tick();
    #2;
    chk("own1_gnt0", gnt0, 1);
    tick();
    req0 = 0;
    tick();

    // read granted to 0, then reset: no rvalid, tie goes to 0
    req0 = 1; we0 = 0; addr0 = 11'h030;
    #2;
    chk("pre_gnt0", gnt0, 1);
    tick();
    rst = 1; req0 = 0;
    #2;
    chk("mr_rv0", rvalid0, 0);
    chk("mr_wren", mem_wren, 0);
    tick();
    rst = 0;
    #2;
    chk("mr_rv0_post", rvalid0, 0);
    chk("mr_addr", mem_addr, 0);
    chk("mr_data", mem_data, 0);
    req0 = 1; req1 = 1; addr0 = 11'h040; addr1 = 11'h041;
    #1;
    chk("mr_tie", {gnt0, gnt1}, 2'b10);
    tick();
    req0 = 0; req1 = 0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
